// File: rtl/jmp_rtn_ctrl.sv
// Control-flow stage between the MC14500B logic unit and the program counter:
// turns JMP/RTN/FLGF pulses into PC loads, keeps a return-address stack, and raises skip/halt.
module jmp_rtn_ctrl #(
    parameter int ADDR_W       = 7,
    parameter int STACK_DEPTH  = 4,
    parameter int HALT_ON_FLGF = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jmp,
    input  logic              rtn,
    input  logic              flgf,
    input  logic              jmp_call,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic [15:0]       pc_addr,
    output logic [15:0]       addr_in,
    output logic              addr_w,
    output logic              skip,
    output logic              halt,
    output logic [4:0]        depth,
    output logic              ovf,
    output logic              unf
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        RUN,
        LOAD,
        SKIP,
        HALT
    } state_t;

    state_t            state;
    logic              ret_pending;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];

    logic [ADDR_W-1:0] ret_addr;
    logic [PTR_W-1:0]  push_ptr;
    logic [PTR_W-1:0]  pop_ptr;
    logic              stack_full;
    logic              stack_empty;
    logic              halt_req;
    logic              do_push;
    logic              unused_pc_bits;

    // Return address is the word after the JMP; wraps naturally at 2^ADDR_W.
    assign ret_addr    = pc_addr[ADDR_W-1:0] + ADDR_W'(1);
    assign push_ptr    = depth[PTR_W-1:0];
    assign pop_ptr     = PTR_W'(depth - 5'd1);
    assign stack_full  = (depth == 5'(STACK_DEPTH));
    assign stack_empty = (depth == 5'd0);
    assign halt_req    = flgf && (HALT_ON_FLGF != 0);
    assign do_push     = !reset && (state == RUN) && !halt_req && jmp && jmp_call && !stack_full;

    assign unused_pc_bits = ^pc_addr[15:ADDR_W];

    // NOTE: the stack array is deliberately not reset; entries above depth are
    // never read, so clearing them would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack[push_ptr] <= ret_addr;
        end
    end

    // NOTE: all state and outputs use non-blocking assignments so every branch
    // reads the pre-edge values of depth/state, exactly as the hardware does.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            ret_pending <= 1'b0;
            addr_in     <= '0;
            addr_w      <= 1'b0;
            skip        <= 1'b0;
            halt        <= 1'b0;
            depth       <= '0;
            ovf         <= 1'b0;
            unf         <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    addr_w <= 1'b0;
                    skip   <= 1'b0;
                    if (halt_req) begin
                        halt  <= 1'b1;
                        state <= HALT;
                    end else if (jmp) begin
                        // jmp wins over a simultaneous rtn; the stack is left alone.
                        addr_in     <= {{(16-ADDR_W){1'b0}}, jmp_target};
                        addr_w      <= 1'b1;
                        ret_pending <= 1'b0;
                        state       <= LOAD;
                        if (jmp_call) begin
                            if (stack_full) begin
                                ovf <= 1'b1;
                            end else begin
                                depth <= depth + 5'd1;
                            end
                        end
                    end else if (rtn) begin
                        if (stack_empty) begin
                            unf <= 1'b1;
                        end else begin
                            addr_in     <= {{(16-ADDR_W){1'b0}}, stack[pop_ptr]};
                            addr_w      <= 1'b1;
                            depth       <= depth - 5'd1;
                            ret_pending <= 1'b1;
                            state       <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    // Strobes arriving now belong to the flushed instruction.
                    addr_w <= 1'b0;
                    if (ret_pending) begin
                        skip  <= 1'b1;
                        state <= SKIP;
                    end else begin
                        state <= RUN;
                    end
                    ret_pending <= 1'b0;
                end

                SKIP: begin
                    skip  <= 1'b0;
                    state <= RUN;
                end

                HALT: begin
                    addr_w <= 1'b0;
                    skip   <= 1'b0;
                    halt   <= 1'b1;
                end

                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jmp_rtn_ctrl.sv
// Directed bench for jmp_rtn_ctrl: plain jump, call/return, nesting/overflow,
// underflow/wrap, strobe collisions, halt and mid-sequence reset.
module tb_jmp_rtn_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        jmp;
    logic        rtn;
    logic        flgf;
    logic        jmp_call;
    logic [6:0]  jmp_target;
    logic [15:0] pc_addr;
    logic [15:0] addr_in;
    logic        addr_w;
    logic        skip;
    logic        halt;
    logic [4:0]  depth;
    logic        ovf;
    logic        unf;

    int checks   = 0;
    int failures = 0;

    jmp_rtn_ctrl #(.ADDR_W(7), .STACK_DEPTH(4), .HALT_ON_FLGF(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .jmp        (jmp),
        .rtn        (rtn),
        .flgf       (flgf),
        .jmp_call   (jmp_call),
        .jmp_target (jmp_target),
        .pc_addr    (pc_addr),
        .addr_in    (addr_in),
        .addr_w     (addr_w),
        .skip       (skip),
        .halt       (halt),
        .depth      (depth),
        .ovf        (ovf),
        .unf        (unf)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        jmp = 1'b0; rtn = 1'b0; flgf = 1'b0; jmp_call = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Hold a one-cycle strobe pattern across exactly one rising edge.
    task automatic pulse(input logic j, input logic r, input logic f, input logic c,
                         input logic [6:0] tgt, input logic [15:0] pc);
        jmp = j; rtn = r; flgf = f; jmp_call = c; jmp_target = tgt; pc_addr = pc;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        jmp_target = 7'h00; pc_addr = 16'h0000;
        do_reset();
        checks++;
        if ({addr_in, addr_w, skip, halt, depth, ovf, unf} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs addr_in=%h addr_w=%b skip=%b halt=%b depth=%0d ovf=%b unf=%b required all zero",
                     addr_in, addr_w, skip, halt, depth, ovf, unf);
        end
    endtask

    task automatic test_plain_jump();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 7'h25, 16'h0003);
        checks++;
        if (addr_w !== 1'b1 || addr_in !== 16'h0025) begin
            failures++;
            $display("FAIL plain_load addr_w=%b addr_in=%h required 1 0025", addr_w, addr_in);
        end
        checks++;
        if (depth !== 5'd0 || skip !== 1'b0) begin
            failures++;
            $display("FAIL plain_depth_skip depth=%0d skip=%b required 0 0", depth, skip);
        end
        step();
        checks++;
        if (addr_w !== 1'b0 || skip !== 1'b0) begin
            failures++;
            $display("FAIL plain_after addr_w=%b skip=%b required 0 0", addr_w, skip);
        end
    endtask

    task automatic test_call_return();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b1, 7'h40, 16'h0010);
        checks++;
        if (addr_w !== 1'b1 || addr_in !== 16'h0040 || depth !== 5'd1) begin
            failures++;
            $display("FAIL call_load addr_w=%b addr_in=%h depth=%0d required 1 0040 1", addr_w, addr_in, depth);
        end
        step();
        checks++;
        if (skip !== 1'b0 || addr_w !== 1'b0) begin
            failures++;
            $display("FAIL call_no_skip skip=%b addr_w=%b required 0 0", skip, addr_w);
        end
        step();
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 16'h0041);
        checks++;
        if (addr_w !== 1'b1 || addr_in !== 16'h0011 || depth !== 5'd0) begin
            failures++;
            $display("FAIL rtn_load addr_w=%b addr_in=%h depth=%0d required 1 0011 0", addr_w, addr_in, depth);
        end
        step();
        checks++;
        if (skip !== 1'b1 || addr_w !== 1'b0) begin
            failures++;
            $display("FAIL rtn_skip skip=%b addr_w=%b required 1 0", skip, addr_w);
        end
        step();
        checks++;
        if (skip !== 1'b0) begin
            failures++;
            $display("FAIL rtn_skip_end skip=%b required 0", skip);
        end
    endtask

    task automatic test_nesting_overflow();
        logic [15:0] exp_ret;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            pulse(1'b1, 1'b0, 1'b0, 1'b1, 7'h50, 16'(i));
            step();
        end
        checks++;
        if (depth !== 5'd4 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL nest_depth depth=%0d ovf=%b required 4 0", depth, ovf);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b1, 7'h60, 16'h0005);
        checks++;
        if (addr_w !== 1'b1 || addr_in !== 16'h0060 || ovf !== 1'b1 || depth !== 5'd4) begin
            failures++;
            $display("FAIL ovf_call addr_w=%b addr_in=%h ovf=%b depth=%0d required 1 0060 1 4",
                     addr_w, addr_in, ovf, depth);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            exp_ret = 16'h0005 - 16'(k);
            pulse(1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 16'h0050);
            checks++;
            if (addr_w !== 1'b1 || addr_in !== exp_ret || depth !== 5'(3 - k)) begin
                failures++;
                $display("FAIL nest_rtn%0d addr_w=%b addr_in=%h depth=%0d required 1 %h %0d",
                         k, addr_w, addr_in, depth, exp_ret, 3 - k);
            end
            step();
            step();
        end
        checks++;
        if (ovf !== 1'b1 || unf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_sticky ovf=%b unf=%b required 1 0", ovf, unf);
        end
    endtask

    task automatic test_underflow_wrap();
        do_reset();
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 16'h0008);
        checks++;
        if (unf !== 1'b1 || addr_w !== 1'b0 || depth !== 5'd0) begin
            failures++;
            $display("FAIL unf_rtn unf=%b addr_w=%b depth=%0d required 1 0 0", unf, addr_w, depth);
        end
        step();
        checks++;
        if (addr_w !== 1'b0 || skip !== 1'b0 || unf !== 1'b1) begin
            failures++;
            $display("FAIL unf_after addr_w=%b skip=%b unf=%b required 0 0 1", addr_w, skip, unf);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b1, 7'h30, 16'h007F);
        step();
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 16'h0030);
        checks++;
        if (addr_w !== 1'b1 || addr_in !== 16'h0000 || depth !== 5'd0) begin
            failures++;
            $display("FAIL wrap_rtn addr_w=%b addr_in=%h depth=%0d required 1 0000 0", addr_w, addr_in, depth);
        end
        step();
        step();
    endtask

    task automatic test_collisions();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b1, 7'h20, 16'h0020);
        step();
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 7'h33, 16'h0020);
        checks++;
        if (addr_w !== 1'b1 || addr_in !== 16'h0033 || depth !== 5'd1) begin
            failures++;
            $display("FAIL jmp_rtn_collide addr_w=%b addr_in=%h depth=%0d required 1 0033 1", addr_w, addr_in, depth);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b1, 7'h44, 16'h0033);
        checks++;
        if (addr_w !== 1'b0 || addr_in !== 16'h0033 || depth !== 5'd1 || skip !== 1'b0) begin
            failures++;
            $display("FAIL jmp_in_load addr_w=%b addr_in=%h depth=%0d skip=%b required 0 0033 1 0",
                     addr_w, addr_in, depth, skip);
        end
        step();
        checks++;
        if (addr_w !== 1'b0) begin
            failures++;
            $display("FAIL jmp_in_load_late addr_w=%b required 0", addr_w);
        end
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 16'h0034);
        checks++;
        if (addr_w !== 1'b1 || addr_in !== 16'h0021 || depth !== 5'd0) begin
            failures++;
            $display("FAIL collide_rtn addr_w=%b addr_in=%h depth=%0d required 1 0021 0", addr_w, addr_in, depth);
        end
        step();
        pulse(1'b1, 1'b0, 1'b0, 1'b1, 7'h55, 16'h0021);
        checks++;
        if (addr_w !== 1'b0 || skip !== 1'b0 || depth !== 5'd0 || addr_in !== 16'h0021) begin
            failures++;
            $display("FAIL jmp_in_skip addr_w=%b skip=%b depth=%0d addr_in=%h required 0 0 0 0021",
                     addr_w, skip, depth, addr_in);
        end
        step();
        checks++;
        if (addr_w !== 1'b0) begin
            failures++;
            $display("FAIL jmp_in_skip_late addr_w=%b required 0", addr_w);
        end
    endtask

    task automatic test_halt_reset();
        do_reset();
        pulse(1'b1, 1'b0, 1'b1, 1'b1, 7'h10, 16'h0002);
        checks++;
        if (halt !== 1'b1 || addr_w !== 1'b0 || depth !== 5'd0) begin
            failures++;
            $display("FAIL halt_flgf halt=%b addr_w=%b depth=%0d required 1 0 0", halt, addr_w, depth);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 7'h11, 16'h0003);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 16'h0003);
        checks++;
        if (halt !== 1'b1 || addr_w !== 1'b0 || skip !== 1'b0 || unf !== 1'b0) begin
            failures++;
            $display("FAIL halt_ignore halt=%b addr_w=%b skip=%b unf=%b required 1 0 0 0", halt, addr_w, skip, unf);
        end
        do_reset();
        checks++;
        if (halt !== 1'b0) begin
            failures++;
            $display("FAIL halt_clear halt=%b required 0", halt);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b1, 7'h40, 16'h0010);
        step();
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 16'h0040);
        step();
        checks++;
        if (skip !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_skip skip=%b required 1", skip);
        end
        reset = 1'b1;
        jmp = 1'b1; jmp_call = 1'b1; jmp_target = 7'h12;
        step();
        reset = 1'b0;
        idle_inputs();
        checks++;
        if ({addr_in, addr_w, skip, halt, depth, ovf, unf} !== 26'd0) begin
            failures++;
            $display("FAIL reset_mid_skip addr_in=%h addr_w=%b skip=%b halt=%b depth=%0d ovf=%b unf=%b required all zero",
                     addr_in, addr_w, skip, halt, depth, ovf, unf);
        end
        step();
        checks++;
        if (addr_w !== 1'b0 || skip !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_skip_run addr_w=%b skip=%b required 0 0", addr_w, skip);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        jmp_target = 7'h00;
        pc_addr    = 16'h0000;
        #1;
        test_reset();
        test_plain_jump();
        test_call_return();
        test_nesting_overflow();
        test_underflow_wrap();
        test_collisions();
        test_halt_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jmp_rtn_ctrl.md
Name: jmp_rtn_ctrl

Overview:
- Control-flow stage between the MC14500B logic unit and the program counter.
- Consumes the LU's one-cycle jmp/rtn/flgf pulses and the current PC address.
- Drives the PC's addr_in/addr_w load port, and keeps a return-address stack for subroutine calls.
- Generates the skip-next-instruction strobe back to the LU after a return, and a sticky halt.

Parameters:
- ADDR_W, 7, width of the program address held on the stack and compared/wrapped (ROM is 128 words).
- STACK_DEPTH, 4, number of return-address entries (1..16).
- HALT_ON_FLGF, 1, when 1 an flgf pulse halts the controller; when 0 flgf is ignored.

Ports:
- clk  in  1  system clock, same clock as LU and PC.
- reset  in  1  synchronous, active-high; clears all state on the clk edge where it is high.
- jmp  in  1  LU JMP strobe, one cycle.
- rtn  in  1  LU RTN strobe, one cycle.
- flgf  in  1  LU FLGF strobe, one cycle.
- jmp_call  in  1  qualifies jmp: 1 = call (push return address), 0 = plain jump.
- jmp_target  in  ADDR_W  jump destination, sampled with jmp.
- pc_addr  in  16  current PC address (PC addr_out); only [ADDR_W-1:0] is used.
- addr_in  out  16  load value to PC, zero-extended from ADDR_W.
- addr_w  out  1  PC load strobe.
- skip  out  1  to LU: suppress the instruction executing this cycle.
- halt  out  1  sticky halt indicator.
- depth  out  5  current stack occupancy, 0..STACK_DEPTH.
- ovf  out  1  sticky: a call was attempted with the stack full.
- unf  out  1  sticky: a return was attempted with the stack empty.

Behaviour:
- Reset values: addr_in=0, addr_w=0, skip=0, halt=0, depth=0, ovf=0, unf=0, state=RUN. Stack contents don't care.
- Reset asserted mid-operation aborts any LOAD/SKIP/HALT; the next cycle is RUN with outputs at reset values.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: RUN, LOAD, SKIP, HALT.
- RUN, jmp=1:
  - addr_in <= {0, jmp_target}; addr_w=1 next cycle; go to LOAD.
  - If jmp_call=1 and depth<STACK_DEPTH: push (pc_addr[ADDR_W-1:0]+1) mod 2^ADDR_W; depth+1.
  - If jmp_call=1 and depth==STACK_DEPTH: no push; ovf<=1; jump still taken.
- RUN, rtn=1 (jmp=0), depth>0:
  - Pop top into addr_in; depth-1; addr_w=1 next cycle; go to LOAD with a return-pending flag.
- RUN, rtn=1 (jmp=0), depth==0: unf<=1; no load, no skip; stay in RUN.
- RUN, jmp and rtn both 1: jmp wins; rtn is dropped; the stack is not popped.
- RUN, flgf=1 and HALT_ON_FLGF=1: go to HALT, halt<=1. This has priority over jmp/rtn in the same cycle.
- LOAD:
  - addr_w=1 for exactly one cycle.
  - jmp/rtn/flgf are ignored; they belong to the pipeline-flushed instruction.
  - Next state: SKIP if return-pending, else RUN.
- SKIP:
  - skip=1 for exactly one cycle, covering the first instruction at the return address (the word after the JMP, e.g. a jump-target operand word).
  - Inputs are ignored. Next state: RUN.
- HALT: addr_w=0, skip=0; all inputs ignored; left only by reset.
- Stack: LIFO, push and pop never in the same cycle. depth saturates at 0 and STACK_DEPTH, never wraps.
- Return addresses wrap: a push at pc_addr = 2^ADDR_W-1 stores 0.
- ovf and unf are sticky until reset.

Test Plan:
- Plain jump: reset, pulse jmp=1, jmp_call=0, jmp_target=0x25 at pc_addr=0x03 → next cycle addr_w=1, addr_in=0x0025; depth stays 0; skip stays 0.
- Call/return: call to 0x40 at pc_addr=0x10 → depth=1. Later rtn → addr_w=1 with addr_in=0x0011, depth=0. The following cycle skip=1 for one cycle, then 0.
- Nesting and overflow: 4 calls from pc_addr 0x01, 0x02, 0x03, 0x04 → depth=4. A 5th call jumps but ovf=1 and depth=4. Four rtns return 0x05, 0x04, 0x03, 0x02 in order.
- Underflow and wrap: rtn with depth=0 → unf=1, addr_w never asserts. A call at pc_addr=0x7F followed by rtn → addr_in=0x0000.
- Collisions: jmp and rtn in the same cycle → jump taken, stack unchanged. jmp pulsed during LOAD or SKIP → ignored, no second addr_w.
- Halt and reset: flgf with jmp in the same cycle → halt=1, no addr_w; further jmp/rtn ignored. Assert reset mid-SKIP → all outputs 0 on the next cycle.
